// File: rtl/gpfp_regfile_pkg.sv
// Shared defaults and types for the dual-bank GP/FP register file.
package regfile_pkg;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int REG_ZERO   = 0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [0:DATA_W_DEF-1] reg_data_t;
endpackage

// File: rtl/gpfp_regfile_regbank.sv
// One register bank: 1 write port, 2 combinational read ports, async clear.
// Same-cycle write-to-read forwarding is compiled in with GPFP_REGFILE_BYPASS_EN.
module regbank
    import regfile_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [0:DATA_W-1] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [0:DATA_W-1] rdata_a,
    output logic [0:DATA_W-1] rdata_b
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [0:DATA_W-1] mem [DEPTH];
    logic              wr_en;

    // A hardwired r0 never stores anything, so its slot stays at reset value.
    assign wr_en = we && !(ZERO_R0 && waddr == ZERO_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic [0:DATA_W-1] val;

            assign ra = (gi == 0) ? raddr_a : raddr_b;

            always_comb begin
                val = mem[ra];
`ifdef GPFP_REGFILE_BYPASS_EN
                if (we && waddr == ra) begin
                    val = wdata;
                end
`endif
                // Zero gating sits last so forwarding can never leak into r0.
                if (ZERO_R0 && ra == ZERO_IDX) begin
                    val = '0;
                end
            end

            if (gi == 0) begin : g_a
                assign rdata_a = val;
            end else begin : g_b
                assign rdata_b = val;
            end
        end
    endgenerate
endmodule

// File: rtl/gpfp_regfile.sv
// GP (r0 hardwired zero) and FP register banks plus committed GP write counter.
// Optional same-cycle forwarding: define GPFP_REGFILE_BYPASS_EN.
module gpfp_regfile
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [0:DATA_W-1] busA,
    output logic [0:DATA_W-1] busB,
    input  logic [ADDR_W-1:0] frs1_addr,
    input  logic [ADDR_W-1:0] frs2_addr,
    output logic [0:DATA_W-1] fbusA,
    output logic [0:DATA_W-1] fbusB,
    input  logic              gp_we,
    input  logic [ADDR_W-1:0] gp_waddr,
    input  logic [0:DATA_W-1] gp_wdata,
    input  logic              fp_we,
    input  logic [ADDR_W-1:0] fp_waddr,
    input  logic [0:DATA_W-1] fp_wdata,
    output logic [15:0]       gp_wr_count
);
    logic [15:0] wr_count_reg;

    regbank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_R0(1'b1)) u_gp (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (gp_we),
        .waddr   (gp_waddr),
        .wdata   (gp_wdata),
        .raddr_a (rs1_addr),
        .raddr_b (rs2_addr),
        .rdata_a (busA),
        .rdata_b (busB)
    );

    regbank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_R0(1'b0)) u_fp (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (fp_we),
        .waddr   (fp_waddr),
        .wdata   (fp_wdata),
        .raddr_a (frs1_addr),
        .raddr_b (frs2_addr),
        .rdata_a (fbusA),
        .rdata_b (fbusB)
    );

    // Counts only writes that actually land; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_reg <= '0;
        end else if (gp_we && gp_waddr != ADDR_W'(REG_ZERO)) begin
            wr_count_reg <= wr_count_reg + 16'd1;
        end
    end

    assign gp_wr_count = wr_count_reg;
endmodule

// File: tb/tb_gpfp_regfile.sv
// Self-checking bench for gpfp_regfile: array model, per-cycle compare, directed cases.
module tb_gpfp_regfile;
    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, frs1_addr, frs2_addr;
    logic [0:31] busA, busB, fbusA, fbusB;
    logic        gp_we, fp_we;
    logic [4:0]  gp_waddr, fp_waddr;
    logic [0:31] gp_wdata, fp_wdata;
    logic [15:0] gp_wr_count;

    bit [31:0] gp_m [32];
    bit [31:0] fp_m [32];
    bit [15:0] cnt;
    int        checks = 0;
    int        errors = 0;
    bit        chk_en = 0;
    bit        bypass;

    gpfp_regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .busA       (busA),
        .busB       (busB),
        .frs1_addr  (frs1_addr),
        .frs2_addr  (frs2_addr),
        .fbusA      (fbusA),
        .fbusB      (fbusB),
        .gp_we      (gp_we),
        .gp_waddr   (gp_waddr),
        .gp_wdata   (gp_wdata),
        .fp_we      (fp_we),
        .fp_waddr   (fp_waddr),
        .fp_wdata   (fp_wdata),
        .gp_wr_count(gp_wr_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
`ifdef GPFP_REGFILE_BYPASS_EN
        bypass = 1;
`else
        bypass = 0;
`endif
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] exp_gp(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bypass && gp_we && gp_waddr == a) return gp_wdata;
        return gp_m[a];
    endfunction

    function automatic bit [31:0] exp_fp(input logic [4:0] a);
        if (bypass && fp_we && fp_waddr == a) return fp_wdata;
        return fp_m[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            gp_m[i] = 0;
            fp_m[i] = 0;
        end
        cnt = 0;
    endtask

    // Advance one edge; the model commits what the DUT saw at that edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            if (gp_we && gp_waddr != 0) begin
                gp_m[gp_waddr] = gp_wdata;
                cnt = cnt + 16'd1;
            end
            if (fp_we) fp_m[fp_waddr] = fp_wdata;
        end
        #1;
    endtask

    task automatic reset_pulse();
        #1 rst_n = 0;
        #1;
        chk("rst_busA", busA, 32'h0);
        chk("rst_busB", busB, 32'h0);
        chk("rst_fbusA", fbusA, 32'h0);
        chk("rst_fbusB", fbusB, 32'h0);
        chk("rst_count", {16'h0, gp_wr_count}, 32'h0);
        clear_model();
        #1 rst_n = 1;
    endtask

    task automatic rand_inputs();
        bit narrow;
        narrow = ($urandom_range(0, 3) == 0);
        rs1_addr  = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        rs2_addr  = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        frs1_addr = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        frs2_addr = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        gp_waddr  = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        fp_waddr  = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        gp_we     = $urandom_range(0, 1);
        fp_we     = $urandom_range(0, 1);
        gp_wdata  = $urandom;
        fp_wdata  = $urandom;
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("busA", busA, exp_gp(rs1_addr));
            chk("busB", busB, exp_gp(rs2_addr));
            chk("fbusA", fbusA, exp_fp(frs1_addr));
            chk("fbusB", fbusB, exp_fp(frs2_addr));
            chk("gp_wr_count", {16'h0, gp_wr_count}, {16'h0, cnt});
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0;
        rs1_addr = 0; rs2_addr = 0; frs1_addr = 0; frs2_addr = 0;
        gp_we = 0; fp_we = 0; gp_waddr = 0; fp_waddr = 0;
        gp_wdata = 0; fp_wdata = 0;
        clear_model();
        #12 rst_n = 1;
        step();
        chk_en = 1;

        // Write coincident with reset is discarded.
        gp_we = 1; gp_waddr = 3; gp_wdata = 32'hFF; rst_n = 0;
        clear_model();
        step();
        rst_n = 1; gp_we = 0; rs1_addr = 3;
        #1;
        chk("rst_wr_r3", busA, 32'h0);
        chk("rst_wr_count", {16'h0, gp_wr_count}, 32'h0);
        $display("reset-coincident write: r3=%08h count=%0d", busA, gp_wr_count);

        // Simultaneous GP/FP write to index 5.
        gp_we = 1; gp_waddr = 5; gp_wdata = 32'h7;
        fp_we = 1; fp_waddr = 5; fp_wdata = 32'h12345678;
        step();
        gp_we = 0; fp_we = 0; rs1_addr = 5; frs2_addr = 5;
        #1;
        chk("wr_busA_r5", busA, 32'h7);
        chk("wr_fbusB_f5", fbusB, 32'h12345678);
        chk("wr_count1", {16'h0, gp_wr_count}, 32'h1);
        $display("write/read: r5=%08h f5=%08h count=%0d", busA, fbusB, gp_wr_count);

        // r0 is hardwired zero on GP only.
        gp_we = 1; gp_waddr = 0; gp_wdata = 32'hDEADBEEF;
        fp_we = 1; fp_waddr = 0; fp_wdata = 32'hDEADBEEF;
        step();
        gp_we = 0; fp_we = 0; rs1_addr = 0; frs1_addr = 0;
        #1;
        chk("r0_busA", busA, 32'h0);
        chk("f0_fbusA", fbusA, 32'hDEADBEEF);
        chk("r0_count", {16'h0, gp_wr_count}, 32'h1);
        $display("r0/f0 write: r0=%08h f0=%08h count=%0d", busA, fbusA, gp_wr_count);

        // Same-cycle hazard on r9.
        gp_we = 1; gp_waddr = 9; gp_wdata = 32'h1;
        step();
        gp_wdata = 32'h2; rs2_addr = 9;
        #1;
        chk("hazard_pre", busB, bypass ? 32'h2 : 32'h1);
        step();
        gp_we = 0;
        #1;
        chk("hazard_post", busB, 32'h2);
        $display("hazard r9: post-edge busB=%08h bypass=%0d", busB, bypass);

        // Mid-cycle reset pulse with populated banks.
        rs1_addr = 5; rs2_addr = 9; frs1_addr = 5; frs2_addr = 0;
        reset_pulse();
        $display("async reset pulse: buses cleared");

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            rand_inputs();
            step();
        end
        gp_we = 0; fp_we = 0;
        $display("random traffic: 2000 cycles, checks so far %0d", checks);

        // Counter wrap.
        reset_pulse();
        gp_we = 1; gp_waddr = 1; rs1_addr = 1;
        for (int n = 0; n < 65535; n++) begin
            gp_wdata = $urandom;
            step();
        end
        chk("wrap_ffff", {16'h0, gp_wr_count}, 32'h0000FFFF);
        step();
        gp_we = 0;
        #1;
        chk("wrap_zero", {16'h0, gp_wr_count}, 32'h0);
        $display("counter wrap: count=%04h", gp_wr_count);

        step();
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
